mips_multicycle: RTL and testbench

//  Multi-cycle MIPS-subset core: one shared ALU, one shared memory port, FSM-sequenced datapath.

---
 rtl/mips_pkg.sv | 70 +++++++
 rtl/mips_multicycle_alu.sv | 26 ++
 rtl/mips_multicycle.sv | 191 +++++++++++++++++++
 tb/tb_mips_multicycle.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, ALU ops,
// FSM states and instruction field helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } aluOp_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_MEMADR,
    S_MEMRD, S_MEMWR, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  function automatic logic [5:0] opOf(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] rsOf(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] rtOf(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] rdOf(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [5:0] functOf(input logic [31:0] instr);
    return instr[5:0];
  endfunction

  function automatic logic [31:0] immOf(input logic [31:0] instr);
    return {{16{instr[15]}}, instr[15:0]};
  endfunction

  function automatic logic legalFunct(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic aluOp_t functToAluOp(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_alu.sv
// Shared combinational ALU: add/sub/and/or/signed slt plus zero flag.
module mips_alu_mc
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  aluOp_t      op,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-subset core: one shared ALU, one req/ready memory port,
// FSM-sequenced datapath with inline 32x32 register file.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ADDR_W       = 32,
  parameter bit          HALT_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halt,
  output logic [31:0]       pc_dbg
);

  state_t      state, nextState;
  logic [31:0] pc, curPc, ir, regA, regB, aluOut, mdr;
  logic [31:0] pcNext, aluOutNext, memAddrNext;
  logic [31:0] gpr [32];
  logic [31:0] rsVal, rtVal, immExt;
  logic [31:0] aluA, aluB, aluY;
  aluOp_t      aluOp;
  logic        aluZero;
  logic        memDone, nextIsMem;
  logic        regWe;
  logic [4:0]  regWaddr;
  logic [31:0] regWdata;

  assign memDone = mem_req & mem_ready;
  assign immExt  = immOf(ir);
  assign rsVal   = (rsOf(ir) == 5'd0) ? '0 : gpr[rsOf(ir)];
  assign rtVal   = (rtOf(ir) == 5'd0) ? '0 : gpr[rtOf(ir)];

  mips_alu_mc u_alu (
    .a    (aluA),
    .b    (aluB),
    .op   (aluOp),
    .y    (aluY),
    .zero (aluZero)
  );

  always_comb begin
    aluA  = pc;
    aluB  = 32'd4;
    aluOp = ALU_ADD;
    case (state)
      S_DECODE: aluB = {immExt[29:0], 2'b00};
      S_EXEC_R: begin
        aluA  = regA;
        aluB  = regB;
        aluOp = functToAluOp(functOf(ir));
      end
      S_EXEC_I, S_MEMADR: begin
        aluA = regA;
        aluB = immExt;
      end
      S_BRANCH: begin
        aluA  = regA;
        aluB  = regB;
        aluOp = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_comb begin
    nextState  = state;
    pcNext     = pc;
    aluOutNext = aluOut;
    regWe      = 1'b0;
    regWaddr   = '0;
    regWdata   = '0;
    case (state)
      S_FETCH: begin
        if (memDone) begin
          pcNext    = aluY;
          nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        aluOutNext = aluY;
        case (opOf(ir))
          OP_RTYPE: nextState = legalFunct(functOf(ir)) ? S_EXEC_R
                              : (HALT_ILLEGAL ? S_HALT : S_FETCH);
          OP_ADDI:         nextState = S_EXEC_I;
          OP_LW, OP_SW:    nextState = S_MEMADR;
          OP_BEQ:          nextState = S_BRANCH;
          OP_J:            nextState = S_JUMP;
          default:         nextState = HALT_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        aluOutNext = aluY;
        nextState  = S_WB_R;
      end
      S_EXEC_I: begin
        aluOutNext = aluY;
        nextState  = S_WB_I;
      end
      S_WB_R: begin
        regWe     = 1'b1;
        regWaddr  = rdOf(ir);
        regWdata  = aluOut;
        nextState = S_FETCH;
      end
      S_WB_I: begin
        regWe     = 1'b1;
        regWaddr  = rtOf(ir);
        regWdata  = aluOut;
        nextState = S_FETCH;
      end
      S_MEMADR: begin
        aluOutNext = aluY;
        nextState  = (opOf(ir) == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD:  if (memDone) nextState = S_WB_MEM;
      S_MEMWR:  if (memDone) nextState = S_FETCH;
      S_WB_MEM: begin
        regWe     = 1'b1;
        regWaddr  = rtOf(ir);
        regWdata  = mdr;
        nextState = S_FETCH;
      end
      S_BRANCH: begin
        if (aluZero) pcNext = aluOut;
        nextState = S_FETCH;
      end
      S_JUMP: begin
        pcNext    = {pc[31:28], ir[25:0], 2'b00};
        nextState = S_FETCH;
      end
      S_HALT:  nextState = S_HALT;
      default: nextState = S_FETCH;
    endcase
  end

  // Request registers are loaded from the state being entered, so a memory
  // state starts with its request already on the bus (zero-wait CPI) and
  // the held pc/aluOut keep address and data stable while ready is low.
  assign nextIsMem   = (nextState == S_FETCH) || (nextState == S_MEMRD) ||
                       (nextState == S_MEMWR);
  assign memAddrNext = ((nextState == S_FETCH) ? pcNext : aluOutNext) & ~32'd3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      curPc     <= RESET_PC;
      ir        <= '0;
      regA      <= '0;
      regB      <= '0;
      aluOut    <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= nextState;
      pc     <= pcNext;
      aluOut <= aluOutNext;
      if (state == S_FETCH && memDone) begin
        ir    <= mem_rdata;
        curPc <= pc;
      end
      if (state == S_DECODE) begin
        regA <= rsVal;
        regB <= rtVal;
      end
      if (state == S_MEMRD && memDone) mdr <= mem_rdata;
      mem_req   <= nextIsMem;
      mem_we    <= (nextState == S_MEMWR);
      mem_addr  <= memAddrNext[ADDR_W-1:0];
      mem_wdata <= (nextState == S_MEMWR) ? regB : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && regWe && regWaddr != 5'd0) gpr[regWaddr] <= regWdata;
  end

  assign halt   = (state == S_HALT);
  assign pc_dbg = (state == S_FETCH) ? pc : curPc;

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: programs in a behavioural wait-state memory,
// results checked through stored words, fetch addresses and cycle spacing.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

  logic [31:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          waitStates = 0;
  int          waitCnt = 0;
  logic [31:0] slowAddr = '1;
  logic        lateReady = 1'b0;
  int          stabErr = 0;
  logic [31:0] rdAddr[$];
  int          rdCyc[$];

  typedef struct {
    int          prog;
    logic [31:0] addr;
    logic [31:0] val;
  } vec_t;
  vec_t vecs[14];

  mips_multicycle #(.RESET_PC(32'h0000_0000), .ADDR_W(32), .HALT_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halt(halt), .pc_dbg(pc_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
  end

  // Memory model: completes on the edge, then decides ready for the next edge.
  always @(posedge clk) begin
    logic        pend, sWe;
    logic [31:0] sAddr, sWd;
    cyc++;
    pend  = mem_req && !mem_ready;
    sAddr = mem_addr;
    sWe   = mem_we;
    sWd   = mem_wdata;
    if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      else begin
        rdAddr.push_back(mem_addr);
        rdCyc.push_back(cyc);
      end
      waitCnt = 0;
    end
    #1;
    if (pend && mem_req && (mem_addr != sAddr || mem_we != sWe || mem_wdata != sWd))
      stabErr++;
    if (mem_req) begin
      mem_rdata = mem[mem_addr[9:2]];
      if (waitCnt >= ((mem_addr == slowAddr) ? 1000 : waitStates)) mem_ready = 1'b1;
      else begin
        mem_ready = 1'b0;
        waitCnt++;
      end
    end else begin
      mem_ready = lateReady;
      waitCnt   = 0;
    end
  end

  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encJ(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  function automatic int cycOf(input logic [31:0] a);
    for (int i = 0; i < rdAddr.size(); i++) if (rdAddr[i] == a) return rdCyc[i];
    return -1000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  task automatic loadProg(input int p);
    for (int i = 0; i < 256; i++) mem[i] = '0;
    case (p)
      0: begin
        put(32'h00, encI(6'h08, 0, 1, 16'd5));
        put(32'h04, encI(6'h08, 0, 2, 16'hFFFD));
        put(32'h08, encR(1, 2, 3, 6'h20));
        put(32'h0C, encR(2, 1, 4, 6'h2A));
        put(32'h10, encR(1, 2, 6, 6'h22));
        put(32'h14, encR(1, 2, 7, 6'h24));
        put(32'h18, encR(1, 2, 8, 6'h25));
        put(32'h1C, encR(1, 2, 9, 6'h2A));
        put(32'h20, encI(6'h08, 0, 0, 16'd7));
        put(32'h24, encI(6'h23, 0, 10, 16'h0200));
        put(32'h28, encI(6'h08, 0, 13, 16'd1));
        put(32'h2C, encR(10, 13, 12, 6'h20));
        put(32'h30, encI(6'h2B, 0, 3, 16'h0300));
        put(32'h34, encI(6'h2B, 0, 4, 16'h0304));
        put(32'h38, encI(6'h2B, 0, 6, 16'h0308));
        put(32'h3C, encI(6'h2B, 0, 7, 16'h030C));
        put(32'h40, encI(6'h2B, 0, 8, 16'h0310));
        put(32'h44, encI(6'h2B, 0, 9, 16'h0314));
        put(32'h48, encI(6'h2B, 0, 0, 16'h0318));
        put(32'h4C, encI(6'h2B, 0, 12, 16'h031C));
        put(32'h50, encI(6'h2B, 0, 2, 16'h0321));
        put(32'h54, 32'hFC00_0000);
        put(32'h200, 32'h7FFF_FFFF);
        put(32'h318, 32'hDEAD_BEEF);
      end
      1: begin
        put(32'h00, encJ(26'd4));
        put(32'h10, encI(6'h08, 0, 1, 16'd5));
        put(32'h14, encI(6'h2B, 0, 1, 16'h0008));
        put(32'h18, encI(6'h23, 0, 5, 16'h0008));
        put(32'h1C, encI(6'h2B, 0, 5, 16'h030C));
        put(32'h20, 32'hFC00_0000);
      end
      2: begin
        put(32'h00, encI(6'h08, 0, 1, 16'd1));
        put(32'h04, encI(6'h08, 0, 2, 16'd2));
        put(32'h08, encI(6'h08, 0, 3, 16'd9));
        put(32'h0C, encR(0, 0, 0, 6'h20));
        put(32'h10, encI(6'h04, 0, 0, 16'd2));
        put(32'h14, 32'hFC00_0000);
        put(32'h18, 32'hFC00_0000);
        put(32'h1C, encI(6'h04, 1, 2, 16'd5));
        put(32'h20, encJ(26'h40));
        put(32'h24, 32'hFC00_0000);
        put(32'h100, encI(6'h2B, 0, 3, 16'h0300));
        put(32'h104, 32'hFC00_0000);
      end
      default: begin
        put(32'h00, encI(6'h23, 0, 5, 16'h0200));
        put(32'h04, encI(6'h2B, 0, 5, 16'h0300));
        put(32'h08, 32'hFC00_0000);
        put(32'h200, 32'h7FFF_FFFF);
      end
    endcase
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rdAddr.delete();
    rdCyc.delete();
    rst = 1'b0;
  endtask

  task automatic runToHalt(input int budget);
    int n = 0;
    int reqs = 0;
    while (!halt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("haltReached", {31'd0, halt}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    check("noReqAfterHalt", reqs, 32'd0);
  endtask

  task automatic checkMem(input int p);
    for (int i = 0; i < 14; i++)
      if (vecs[i].prog == p)
        check($sformatf("mem@%h", vecs[i].addr), mem[vecs[i].addr[9:2]], vecs[i].val);
  endtask

  initial begin
    int n;
    vecs[0]  = '{0, 32'h300, 32'h0000_0002};
    vecs[1]  = '{0, 32'h304, 32'h0000_0001};
    vecs[2]  = '{0, 32'h308, 32'h0000_0008};
    vecs[3]  = '{0, 32'h30C, 32'h0000_0005};
    vecs[4]  = '{0, 32'h310, 32'hFFFF_FFFD};
    vecs[5]  = '{0, 32'h314, 32'h0000_0000};
    vecs[6]  = '{0, 32'h318, 32'h0000_0000};
    vecs[7]  = '{0, 32'h31C, 32'h8000_0000};
    vecs[8]  = '{0, 32'h320, 32'hFFFF_FFFD};
    vecs[9]  = '{1, 32'h008, 32'h0000_0005};
    vecs[10] = '{1, 32'h30C, 32'h0000_0005};
    vecs[11] = '{2, 32'h300, 32'h0000_0009};
    vecs[12] = '{2, 32'h014, 32'hFC00_0000};
    vecs[13] = '{3, 32'h300, 32'h7FFF_FFFF};

    // Reset state and first fetch
    rst = 1'b1;
    loadProg(0);
    repeat (2) @(negedge clk);
    check("rstReq", {31'd0, mem_req}, 32'd0);
    check("rstWe", {31'd0, mem_we}, 32'd0);
    check("rstHalt", {31'd0, halt}, 32'd0);
    check("rstPc", pc_dbg, 32'h0);
    check("rstAddr", mem_addr, 32'h0);
    rdAddr.delete();
    rdCyc.delete();
    rst = 1'b0;
    @(negedge clk);
    check("firstFetchReq", {31'd0, mem_req}, 32'd1);
    check("firstFetchAddr", mem_addr, 32'h0);

    // Arithmetic, $0, overflow wrap, unaligned store, illegal halt
    runToHalt(400);
    check("haltPc", pc_dbg, 32'h54);
    checkMem(0);
    check("cpiAddi", cycOf(32'h04) - cycOf(32'h00), 32'd4);
    check("cpiRtype", cycOf(32'h0C) - cycOf(32'h08), 32'd4);
    check("cpiLw", cycOf(32'h28) - cycOf(32'h24), 32'd5);
    check("cpiSw", cycOf(32'h34) - cycOf(32'h30), 32'd4);

    // Three wait states on every transfer
    loadProg(1);
    waitStates = 3;
    doReset();
    runToHalt(400);
    checkMem(1);
    check("cpiSwWait", cycOf(32'h18) - cycOf(32'h14), 32'd10);
    check("cpiLwWait", cycOf(32'h1C) - cycOf(32'h18), 32'd11);
    check("stableDuringWait", stabErr, 32'd0);
    waitStates = 0;

    // Control flow
    loadProg(2);
    doReset();
    runToHalt(400);
    checkMem(2);
    check("fetchAfterBeqTaken", rdAddr[5], 32'h1C);
    check("fetchAfterBeqNot", rdAddr[6], 32'h20);
    check("fetchAfterJump", rdAddr[7], 32'h100);
    check("cpiBeqTaken", cycOf(32'h1C) - cycOf(32'h10), 32'd3);
    check("cpiBeqNot", cycOf(32'h20) - cycOf(32'h1C), 32'd3);
    check("cpiJump", cycOf(32'h100) - cycOf(32'h20), 32'd3);

    // Reset while a load waits on ready
    loadProg(3);
    slowAddr = 32'h200;
    doReset();
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 32'h200) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("lwReqSeen", {31'd0, mem_req}, 32'd1);
    repeat (2) @(negedge clk);
    check("lwStillWaiting", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    lateReady = 1'b1;
    slowAddr = '1;
    @(negedge clk);
    check("reqDropOnRst", {31'd0, mem_req}, 32'd0);
    rdAddr.delete();
    rdCyc.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lateReady = 1'b0;
    runToHalt(400);
    check("restartAtResetPc", (rdAddr.size() > 0) ? rdAddr[0] : 32'hFFFF_FFFF, 32'h0);
    checkMem(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
